// File: rtl/ttt_pkg.sv
// Shared types and arithmetic helpers for the token router and its drain channels.
package ttt_pkg;

  localparam int TTT_NUM_SOURCES     = 4;
  localparam int TTT_NEW_TOKENS_BITS = 4;
  localparam int TTT_WEIGHT_BITS     = 4;
  localparam int TTT_PENDING_BITS    = 8;

  typedef logic signed [TTT_NEW_TOKENS_BITS-1:0] new_tokens_t;
  typedef logic signed [TTT_WEIGHT_BITS-1:0]     weight_t;
  typedef logic signed [TTT_PENDING_BITS-1:0]    pending_t;

  // Clamp a signed value into the range of a signed field 'width' bits wide.
  function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/ttt_token_router_if.sv
// Source-side events/weights and core-side token deltas of one token router.
interface ttt_token_router_if
  import ttt_pkg::*;
#(
  parameter int NUM_SOURCES     = TTT_NUM_SOURCES,
  parameter int NEW_TOKENS_BITS = TTT_NEW_TOKENS_BITS,
  parameter int WEIGHT_BITS     = TTT_WEIGHT_BITS
);
  logic [NUM_SOURCES-1:0]             src_token_start;
  logic [NUM_SOURCES-1:0]             src_token_end;
  logic [NUM_SOURCES*WEIGHT_BITS-1:0] good_weights;
  logic [NUM_SOURCES*WEIGHT_BITS-1:0] bad_weights;
  logic signed [NEW_TOKENS_BITS-1:0]  new_good_tokens;
  logic signed [NEW_TOKENS_BITS-1:0]  new_bad_tokens;
  logic [NUM_SOURCES-1:0]             active;
  logic                               idle;
  logic                               overflow;

  modport master (
    output src_token_start, src_token_end, good_weights, bad_weights,
    input  new_good_tokens, new_bad_tokens, active, idle, overflow
  );

  modport slave (
    input  src_token_start, src_token_end, good_weights, bad_weights,
    output new_good_tokens, new_bad_tokens, active, idle, overflow
  );
endinterface

// File: rtl/ttt_token_drain.sv
// One token channel: residual accumulator, clamp to the output range and sticky overflow.
module ttt_token_drain
  import ttt_pkg::*;
#(
  parameter int NEW_TOKENS_BITS = TTT_NEW_TOKENS_BITS,
  parameter int PENDING_BITS    = TTT_PENDING_BITS
) (
  input  logic                              clock_fast,
  input  logic                              reset,
  input  logic signed [PENDING_BITS:0]      i_delta,
  output logic signed [NEW_TOKENS_BITS-1:0] o_tokens,
  output logic                              o_residualZero,
  output logic                              o_overflow
);
  localparam int SW = PENDING_BITS + 2;

  logic signed [PENDING_BITS-1:0]    r_residual;
  logic signed [NEW_TOKENS_BITS-1:0] r_tokens;
  logic                              r_overflow;

  logic signed [SW-1:0]           w_sum;
  logic signed [SW-1:0]           w_emit;
  logic signed [SW-1:0]           w_remainder;
  logic signed [PENDING_BITS-1:0] w_remSat;
  logic                           w_saturated;

  // Whatever does not fit in one output step stays behind for later cycles.
  always_comb begin
    w_sum       = SW'(r_residual) + SW'(i_delta);
    w_emit      = SW'(sat(32'(w_sum), NEW_TOKENS_BITS));
    w_remainder = w_sum - w_emit;
    w_remSat    = PENDING_BITS'(sat(32'(w_remainder), PENDING_BITS));
    w_saturated = (32'(w_remainder) != 32'(w_remSat));
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_residual <= '0;
      r_tokens   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_residual <= w_remSat;
      r_tokens   <= NEW_TOKENS_BITS'(w_emit);
      r_overflow <= r_overflow | w_saturated;
    end
  end

  assign o_tokens       = r_tokens;
  assign o_residualZero = (r_residual == '0);
  assign o_overflow     = r_overflow;
endmodule

// File: rtl/ttt_token_router.sv
// Fan-in of upstream token start/end pulses into weighted good/bad token deltas for one core.
module ttt_token_router
  import ttt_pkg::*;
#(
  parameter int NUM_SOURCES     = TTT_NUM_SOURCES,
  parameter int NEW_TOKENS_BITS = TTT_NEW_TOKENS_BITS,
  parameter int WEIGHT_BITS     = TTT_WEIGHT_BITS,
  parameter int PENDING_BITS    = TTT_PENDING_BITS
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  ttt_token_router_if.slave    bus
);
  localparam int DW = PENDING_BITS + 1;

  logic [NUM_SOURCES-1:0]        r_active;
  logic signed [WEIGHT_BITS-1:0] r_goodW [NUM_SOURCES];
  logic signed [WEIGHT_BITS-1:0] r_badW  [NUM_SOURCES];

  logic [NUM_SOURCES-1:0]            w_startEv;
  logic [NUM_SOURCES-1:0]            w_endEv;
  logic signed [DW-1:0]              w_deltaGood;
  logic signed [DW-1:0]              w_deltaBad;
  logic signed [NEW_TOKENS_BITS-1:0] w_goodTokens;
  logic signed [NEW_TOKENS_BITS-1:0] w_badTokens;
  logic                              w_goodZero;
  logic                              w_badZero;
  logic                              w_goodOvf;
  logic                              w_badOvf;

  // Only a clean start on an idle source or a clean end on a held source counts.
  assign w_startEv = bus.src_token_start & ~bus.src_token_end & ~r_active;
  assign w_endEv   = bus.src_token_end & ~bus.src_token_start & r_active;

  always_comb begin
    w_deltaGood = '0;
    w_deltaBad  = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_startEv[i]) begin
        w_deltaGood = w_deltaGood + DW'($signed(bus.good_weights[i*WEIGHT_BITS +: WEIGHT_BITS]));
        w_deltaBad  = w_deltaBad  + DW'($signed(bus.bad_weights[i*WEIGHT_BITS +: WEIGHT_BITS]));
      end else if (w_endEv[i]) begin
        w_deltaGood = w_deltaGood - DW'(r_goodW[i]);
        w_deltaBad  = w_deltaBad  - DW'(r_badW[i]);
      end
    end
  end

  // An end withdraws exactly what its start contributed, so the weight is latched at start.
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_active <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        r_goodW[i] <= '0;
        r_badW[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (w_startEv[i]) begin
          r_active[i] <= 1'b1;
          r_goodW[i]  <= bus.good_weights[i*WEIGHT_BITS +: WEIGHT_BITS];
          r_badW[i]   <= bus.bad_weights[i*WEIGHT_BITS +: WEIGHT_BITS];
        end else if (w_endEv[i]) begin
          r_active[i] <= 1'b0;
        end
      end
    end
  end

  ttt_token_drain #(.NEW_TOKENS_BITS(NEW_TOKENS_BITS), .PENDING_BITS(PENDING_BITS)) u_goodDrain (
    .clock_fast     (clock_fast),
    .reset          (reset),
    .i_delta        (w_deltaGood),
    .o_tokens       (w_goodTokens),
    .o_residualZero (w_goodZero),
    .o_overflow     (w_goodOvf)
  );

  ttt_token_drain #(.NEW_TOKENS_BITS(NEW_TOKENS_BITS), .PENDING_BITS(PENDING_BITS)) u_badDrain (
    .clock_fast     (clock_fast),
    .reset          (reset),
    .i_delta        (w_deltaBad),
    .o_tokens       (w_badTokens),
    .o_residualZero (w_badZero),
    .o_overflow     (w_badOvf)
  );

  assign bus.new_good_tokens = w_goodTokens;
  assign bus.new_bad_tokens  = w_badTokens;
  assign bus.active          = r_active;
  assign bus.overflow        = w_goodOvf | w_badOvf;
  assign bus.idle            = w_goodZero & w_badZero & (w_goodTokens == '0) & (w_badTokens == '0);
endmodule

// File: tb/tb_ttt_token_router.sv
// Scoreboard bench: two routers (8-bit and 5-bit residuals) share stimulus and are checked each cycle.
module tb_ttt_token_router;
  localparam int NS = 4;
  localparam int NT = 4;
  localparam int WB = 4;

  logic        clock_fast = 1'b0;
  logic        reset      = 1'b1;
  logic [3:0]  sStart     = '0;
  logic [3:0]  sEnd       = '0;
  logic [15:0] gW         = '0;
  logic [15:0] bW         = '0;

  always #5 clock_fast = ~clock_fast;

  ttt_token_router_if #(.NUM_SOURCES(NS), .NEW_TOKENS_BITS(NT), .WEIGHT_BITS(WB)) busA ();
  ttt_token_router_if #(.NUM_SOURCES(NS), .NEW_TOKENS_BITS(NT), .WEIGHT_BITS(WB)) busB ();

  assign busA.src_token_start = sStart;
  assign busA.src_token_end   = sEnd;
  assign busA.good_weights    = gW;
  assign busA.bad_weights     = bW;
  assign busB.src_token_start = sStart;
  assign busB.src_token_end   = sEnd;
  assign busB.good_weights    = gW;
  assign busB.bad_weights     = bW;

  ttt_token_router #(.NUM_SOURCES(NS), .NEW_TOKENS_BITS(NT), .WEIGHT_BITS(WB), .PENDING_BITS(8)) dutA (
    .clock_fast (clock_fast),
    .reset      (reset),
    .bus        (busA.slave)
  );

  ttt_token_router #(.NUM_SOURCES(NS), .NEW_TOKENS_BITS(NT), .WEIGHT_BITS(WB), .PENDING_BITS(5)) dutB (
    .clock_fast (clock_fast),
    .reset      (reset),
    .bus        (busB.slave)
  );

  typedef struct {
    int res;
    int out;
    bit ovf;
  } chan_t;

  chan_t       cAg, cAb, cBg, cBb;
  bit [3:0]    mActive;
  int          mGl [4];
  int          mBl [4];
  logic [27:0] expQ [$];
  int          cmpCnt  = 0;
  int          failCnt = 0;

  function automatic int clampI(int v, int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic chan_t chanStep(chan_t c, int delta, int pb);
    chan_t n;
    int s, r;
    s     = c.res + delta;
    n.out = clampI(s, NT);
    r     = s - n.out;
    n.res = clampI(r, pb);
    n.ovf = c.ovf || (n.res != r);
    return n;
  endfunction

  function automatic chan_t zeroChan();
    chan_t z;
    z.res = 0;
    z.out = 0;
    z.ovf = 1'b0;
    return z;
  endfunction

  function automatic int wOf(logic [15:0] v, int i);
    logic signed [3:0] t;
    t = v[i*4 +: 4];
    return int'(t);
  endfunction

  // Field order: goodA, badA, goodB, badB, activeA, activeB, idleA, idleB, ovfA, ovfB
  function automatic logic [27:0] expVec();
    bit idleA, idleB;
    idleA = (cAg.res == 0) && (cAg.out == 0) && (cAb.res == 0) && (cAb.out == 0);
    idleB = (cBg.res == 0) && (cBg.out == 0) && (cBb.res == 0) && (cBb.out == 0);
    return {4'(cAg.out), 4'(cAb.out), 4'(cBg.out), 4'(cBb.out), mActive, mActive,
            idleA, idleB, cAg.ovf | cAb.ovf, cBg.ovf | cBb.ovf};
  endfunction

  function automatic logic [27:0] obsVec();
    return {busA.new_good_tokens, busA.new_bad_tokens, busB.new_good_tokens, busB.new_bad_tokens,
            busA.active, busB.active, busA.idle, busB.idle, busA.overflow, busB.overflow};
  endfunction

  task automatic applyStimulus(input logic [3:0] st, input logic [3:0] en, input bit rst);
    int dG, dB;
    @(negedge clock_fast);
    sStart = st;
    sEnd   = en;
    reset  = rst;
    if (rst) begin
      mActive = '0;
      for (int i = 0; i < 4; i++) begin
        mGl[i] = 0;
        mBl[i] = 0;
      end
      cAg = zeroChan(); cAb = zeroChan(); cBg = zeroChan(); cBb = zeroChan();
    end else begin
      dG = 0;
      dB = 0;
      for (int i = 0; i < 4; i++) begin
        if (st[i] && !en[i] && !mActive[i]) begin
          mActive[i] = 1'b1;
          mGl[i] = wOf(gW, i);
          mBl[i] = wOf(bW, i);
          dG += mGl[i];
          dB += mBl[i];
        end else if (en[i] && !st[i] && mActive[i]) begin
          mActive[i] = 1'b0;
          dG -= mGl[i];
          dB -= mBl[i];
        end
      end
      cAg = chanStep(cAg, dG, 8);
      cAb = chanStep(cAb, dB, 8);
      cBg = chanStep(cBg, dG, 5);
      cBb = chanStep(cBb, dB, 5);
    end
    expQ.push_back(expVec());
    @(posedge clock_fast);
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] want;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'h0, 4'h0, 1'b1);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL reset cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
    applyStimulus(4'h0, 4'h0, 1'b0);
    void'(expQ.pop_front());
  endtask

  task automatic test_single();
    logic [3:0]  stT [9] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  enT [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [27:0] want;
    gW = 16'h0003;
    bW = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(stT[k], enT[k], 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL single cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
  endtask

  task automatic test_simul();
    logic [3:0]  stT [11] = '{4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  enT [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [27:0] want;
    gW = 16'h0777;
    bW = 16'h0000;
    for (int k = 0; k < 11; k++) begin
      applyStimulus(stT[k], enT[k], 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL simul cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
  endtask

  task automatic test_bad();
    logic [3:0]  stT [8] = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  enT [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0};
    logic [27:0] want;
    gW = 16'h0000;
    bW = 16'h0088;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(stT[k], enT[k], 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL bad_weight cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
  endtask

  task automatic test_weight_change();
    logic [3:0]  stT [6] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  enT [6] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    logic [27:0] want;
    int          integral = 0;
    gW = 16'h0005;
    bW = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) gW = 16'h0002;
      applyStimulus(stT[k], enT[k], 1'b0);
      integral += int'(busA.new_good_tokens);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL weight_change cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
    cmpCnt++;
    if (integral !== 0) begin
      failCnt++;
      $display("[TB] FAIL weight_change_integral got %0d want 0", integral);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  stT [8] = '{4'h1, 4'h1, 4'h0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [3:0]  enT [8] = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h1, 4'h1, 4'h0, 4'h0};
    logic [27:0] want;
    gW = 16'h0003;
    bW = 16'h000E;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(stT[k], enT[k], 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL illegal cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  stT [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic [3:0]  enT [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
    logic [27:0] want;
    gW = 16'h7777;
    bW = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(stT[k], enT[k], 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL overflow cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
    cmpCnt++;
    if (busB.overflow !== 1'b1) begin
      failCnt++;
      $display("[TB] FAIL overflow_sticky got %b want 1", busB.overflow);
    end
    applyStimulus(4'h0, 4'h0, 1'b1);
    want = expQ.pop_front();
    cmpCnt++;
    if (obsVec() !== want || busB.overflow !== 1'b0 || busB.new_good_tokens !== 4'sd0) begin
      failCnt++;
      $display("[TB] FAIL reset_mid_drain got %h want %h", obsVec(), want);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'h0, (k == 1) ? 4'hF : 4'h0, 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL after_reset cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] want;
    int          v;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++) begin
        v = int'($urandom_range(14)) - 7;
        gW[i*4 +: 4] = 4'(v);
        v = int'($urandom_range(14)) - 7;
        bW[i*4 +: 4] = 4'(v);
      end
      applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);
      want = expQ.pop_front();
      cmpCnt++;
      if (obsVec() !== want) begin
        failCnt++;
        $display("[TB] FAIL back_to_back cyc%0d got %h want %h", k, obsVec(), want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_bad();
    test_weight_change();
    test_illegal();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
    $finish;
  end
endmodule
